// File: rtl/accel_axis_filter_pkg.sv
// accel_axis_filter_pkg: shared types and helpers for the accelerometer filter
package accel_axis_filter_pkg;
  localparam int DATA_W_DEF = 12;
  typedef enum logic {FILL, RUN} fill_e;
  // Negation of the most negative w-bit value clamps to the most positive one
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    return v == lo ? -lo - 32'sd1 : -v;
  endfunction
endpackage

// File: rtl/accel_axis_filter_avg.sv
// accel_axis_filter_avg: one axis ring-buffer moving average, zero offset and dead zone
module accel_axis_filter_avg
  import accel_axis_filter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 2,
  parameter int DEADZONE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     fire_i,
  input  logic                     cal_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] out_o
);
  localparam int D  = 1 << AVG_LOG2;
  localparam int SW = DATA_W + AVG_LOG2;
  localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int RD = 1 << PW;
  logic signed [DATA_W-1:0] ring_q [RD];
  logic [PW-1:0] wp_q, wp_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [DATA_W-1:0] off_q, off_d, out_q, out_d, avg, v;
  logic signed [DATA_W:0] diff, mag;
  assign out_o = out_q;
  always_comb begin
    wp_d  = wp_q == PW'(D - 1) ? '0 : wp_q + PW'(1);
    sum_d = sum_q + SW'(sample_i) - SW'(ring_q[wp_q]);
    avg   = DATA_W'(sum_q >>> AVG_LOG2);
    off_d = cal_i ? avg : off_q;
    diff  = (DATA_W+1)'(avg) - (DATA_W+1)'(off_d);
    v     = diff[DATA_W] != diff[DATA_W-1] ? {diff[DATA_W], {(DATA_W-1){~diff[DATA_W]}}} : diff[DATA_W-1:0];
    mag   = v[DATA_W-1] ? -(DATA_W+1)'(v) : (DATA_W+1)'(v);
    out_d = mag <= (DATA_W+1)'(DEADZONE) ? '0 : v;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RD; i++) ring_q[i] <= '0;
      wp_q  <= '0;
      sum_q <= '0;
      off_q <= '0;
      out_q <= '0;
    end else begin
      if (push_i) begin
        ring_q[wp_q] <= sample_i;
        wp_q         <= wp_d;
        sum_q        <= sum_d;
      end
      if (fire_i) begin
        off_q <= off_d;
        out_q <= out_d;
      end
    end
endmodule

// File: rtl/accel_axis_filter.sv
// accel_axis_filter: orientation, moving average, zero calibration and dead zone for X/Y/Z samples
module accel_axis_filter
  import accel_axis_filter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 2,
  parameter int SWAP_XY  = 1,
  parameter int NEG_X    = 1,
  parameter int NEG_Y    = 0,
  parameter int NEG_Z    = 0,
  parameter int DEADZONE = 0
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic signed [DATA_W-1:0] in_z,
  input  logic                     cal_req,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y,
  output logic signed [DATA_W-1:0] out_z,
  output logic                     out_valid,
  output logic                     cal_done,
  output logic                     filled
);
  localparam int D  = 1 << AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  fill_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic v1_q, v2_q, pend_q, pend_d, vld_q, done_q, fire, cal;
  logic signed [DATA_W-1:0] px, py, s1_d [3], s1_q [3], o [3];
  always_comb begin
    px      = SWAP_XY != 0 ? in_y : in_x;
    py      = SWAP_XY != 0 ? in_x : in_y;
    s1_d[0] = NEG_X != 0 ? DATA_W'(sat_neg(32'(px), DATA_W)) : px;
    s1_d[1] = NEG_Y != 0 ? DATA_W'(sat_neg(32'(py), DATA_W)) : py;
    s1_d[2] = NEG_Z != 0 ? DATA_W'(sat_neg(32'(in_z), DATA_W)) : in_z;
    fire    = v2_q && state_q == RUN;
    cal     = fire && pend_q;
    pend_d  = cal_req || (pend_q && !cal);
    cnt_d   = v1_q && cnt_q != CW'(D) ? cnt_q + CW'(1) : cnt_q;
    state_d = state_q == FILL && v1_q && cnt_q == CW'(D - 1) ? RUN : state_q;
  end
  // v1_q/v2_q track samples entering stage 2 and stage 3
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      s1_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= in_valid;
      v2_q    <= v1_q;
      pend_q  <= pend_d;
      vld_q   <= fire;
      done_q  <= cal;
      if (in_valid) s1_q <= s1_d;
    end
  for (genvar a = 0; a < 3; a++) begin : g_axis
    accel_axis_filter_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .DEADZONE(DEADZONE)) u_avg (
      .clk(CLK), .rst_n(rst), .push_i(v1_q), .fire_i(fire), .cal_i(cal),
      .sample_i(s1_q[a]), .out_o(o[a])
    );
  end
  assign out_x     = o[0];
  assign out_y     = o[1];
  assign out_z     = o[2];
  assign out_valid = vld_q;
  assign cal_done  = done_q;
  assign filled    = state_q == RUN;
endmodule

// File: tb/tb_accel_axis_filter.sv
// tb_accel_axis_filter: directed checks of fill, averaging, saturation, calibration, dead zone and reset
module tb_accel_axis_filter;
  localparam int W = 12;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, cal_req = 1'b0;
  logic signed [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic signed [W-1:0] ax, ay, az, bx, by, bz;
  logic av, ad, af, bv, bd, bf;
  int checks = 0, failures = 0, a_nv = 0, a_nd = 0, nv0, nd0;
  always #5 clk = ~clk;
  accel_axis_filter u_a (
    .CLK(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .cal_req(cal_req), .out_x(ax), .out_y(ay), .out_z(az), .out_valid(av), .cal_done(ad), .filled(af)
  );
  accel_axis_filter #(.AVG_LOG2(0), .SWAP_XY(0), .NEG_X(0), .DEADZONE(8)) u_b (
    .CLK(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .cal_req(cal_req), .out_x(bx), .out_y(by), .out_z(bz), .out_valid(bv), .cal_done(bd), .filled(bf)
  );
  always @(negedge clk) begin
    if (av) a_nv++;
    if (ad) a_nd++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input int x, input int y, input int z, input logic c = 1'b0);
    in_x = W'(x); in_y = W'(y); in_z = W'(z);
    in_valid = 1'b1; cal_req = c;
    @(negedge clk);
    in_valid = 1'b0; cal_req = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask
  initial begin
    do_reset;
    chk("rst_out_x", ax, 0); chk("rst_valid", av, 0); chk("rst_filled", af, 0); chk("rst_cal_done", ad, 0);
    repeat (3) send(100, -50, 256);
    step(4);
    chk("fill3_valid_cnt", a_nv, 0); chk("fill3_filled", af, 0);
    send(100, -50, 256);
    step(1);
    chk("fill4_filled", af, 1); chk("fill4_early_valid", av, 0);
    step(1);
    chk("fill4_valid", av, 1); chk("steady_x", ax, 50); chk("steady_y", ay, 100); chk("steady_z", az, 256);
    step(2);
    chk("fill4_valid_cnt", a_nv, 1);
    for (int i = 0; i <= 4; i++) send(100, -4 * i, 256);
    step(2);
    chk("wrap_x", ax, 10); chk("wrap_valid", av, 1);
    send(100, 1, 256);
    repeat (3) send(100, 2, 256);
    step(2);
    chk("floor_x", ax, -2);
    repeat (4) send(100, -2048, 256);
    step(2);
    chk("satneg_x", ax, 2047); chk("satneg_y", ay, 100);
    repeat (4) send(300, 0, 0);
    step(2);
    chk("cal_pre_y", ay, 300); chk("cal_pre_x", ax, 0);
    nd0 = a_nd;
    send(300, 0, 0, 1'b1);
    step(2);
    chk("cal_y", ay, 0); chk("cal_done", ad, 1);
    repeat (4) send(340, 0, 0);
    step(2);
    chk("cal_shift_y", ay, 40); chk("cal_once", a_nd - nd0, 1);
    nd0 = a_nd;
    cal_req = 1'b1; step(1); cal_req = 1'b0; step(1);
    cal_req = 1'b1; step(1); cal_req = 1'b0;
    send(340, 0, 0);
    step(2);
    chk("absorb_y", ay, 0);
    step(3);
    chk("absorb_once", a_nd - nd0, 1);
    do_reset;
    cal_req = 1'b1; step(1); cal_req = 1'b0;
    repeat (4) send(300, 0, 0);
    step(2);
    chk("fillcal_valid", av, 1); chk("fillcal_done", ad, 1); chk("fillcal_y", ay, 0);
    do_reset;
    send(-8, 8, 9);
    step(2);
    chk("dz_valid", bv, 1); chk("dz_x", bx, 0); chk("dz_y", by, 0); chk("dz_z", bz, 9);
    send(-9, 0, -8);
    step(2);
    chk("dz_x9", bx, -9); chk("dz_z8", bz, 0);
    do_reset;
    repeat (4) send(10, 20, 30);
    step(2);
    chk("mid_pre_valid", av, 1); chk("mid_pre_x", ax, -20); chk("mid_pre_y", ay, 10);
    step(1);
    nv0 = a_nv;
    send(10, 20, 30);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(5);
    chk("mid_valid_cnt", a_nv - nv0, 0); chk("mid_out_x", ax, 0); chk("mid_out_y", ay, 0);
    chk("mid_out_z", az, 0); chk("mid_valid", av, 0); chk("mid_filled", af, 0); chk("mid_b_x", bx, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
